totd_40mhz_ctrl: RTL

Sequencer and configuration controller for the 40 MHz compatibility ToTd trigger datapath. It generates the 3-phase ENABLE40 strobe from CLK120 and holds shadow and active copies of all ToTd settings. Shadow settings move to the active outputs atomically on a 40 MHz boundary. It also gates the raw ToTd trigger with a settle (window refill) interval and a post-trigger holdoff, and counts accepted triggers.

---
 rtl/totd_40mhz_ctrl_if.sv | 25 ++
 rtl/totd_40mhz_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/totd_40mhz_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | totd_40mhz_ctrl_if                                                        |
// | Configuration write / commit handshake for the ToTd 40 MHz controller.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface totd_40mhz_ctrl_if;
    logic        CFG_WR;
    logic [3:0]  CFG_ADDR;
    logic [31:0] CFG_DATA;
    logic        CFG_READY;
    logic        CFG_COMMIT;
    logic        COMMIT_DONE;

    modport master (
        output CFG_WR, CFG_ADDR, CFG_DATA, CFG_COMMIT,
        input  CFG_READY, COMMIT_DONE
    );

    modport slave (
        input  CFG_WR, CFG_ADDR, CFG_DATA, CFG_COMMIT,
        output CFG_READY, COMMIT_DONE
    );
endinterface
`default_nettype wire

// File: rtl/totd_40mhz_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | totd_40mhz_ctrl                                                           |
// | ENABLE40 sequencer, shadow/active ToTd settings and trigger gating.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module totd_40mhz_ctrl #(
    parameter int ADC_WIDTH    = 12,
    parameter int OCC_BITS     = 7,
    parameter int FD_BITS      = 12,
    parameter int FN_BITS      = 12,
    parameter int INT_BITS     = 19,
    parameter int SETTLE_TICKS = 121,
    parameter int CNT_BITS     = 16
) (
    input  wire logic                 CLK120,
    input  wire logic                 RSTN,
    totd_40mhz_ctrl_if.slave          cfg,
    output logic [1:0]                ENABLE40,
    output logic [ADC_WIDTH-1:0]      THRES0,
    output logic [ADC_WIDTH-1:0]      THRES1,
    output logic [ADC_WIDTH-1:0]      THRES2,
    output logic [ADC_WIDTH-1:0]      UP0,
    output logic [ADC_WIDTH-1:0]      UP1,
    output logic [ADC_WIDTH-1:0]      UP2,
    output logic [2:0]                TRIG_ENABLE,
    output logic [1:0]                MULTIPLICITY,
    output logic [OCC_BITS-1:0]       OCCUPANCY,
    output logic [FD_BITS-1:0]        FD,
    output logic [FN_BITS-1:0]        FN,
    output logic [INT_BITS-1:0]       INT,
    input  wire logic                 TRIG_IN,
    output logic                      TRIG_OUT,
    input  wire logic                 CNT_CLR,
    output logic [CNT_BITS-1:0]       TRIG_COUNT,
    output logic                      BUSY
);

    localparam int c_SW = $clog2(SETTLE_TICKS + 1);
    localparam int c_TW = (c_SW > 16) ? c_SW : 16;

    typedef enum logic [1:0] {
        S_FLUSH   = 2'd0,
        S_ARMED   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    // Settings are kept as one flat set so shadow->active is a single copy.
    typedef struct packed {
        logic [ADC_WIDTH-1:0] thr0, thr1, thr2;
        logic [ADC_WIDTH-1:0] up0, up1, up2;
        logic [2:0]           ten;
        logic [1:0]           mult;
        logic [OCC_BITS-1:0]  occ;
        logic [FD_BITS-1:0]   fd;
        logic [FN_BITS-1:0]   fn;
        logic [INT_BITS-1:0]  intg;
        logic [15:0]          hold;
    } cfg_t;

    localparam cfg_t c_CFG_RST = '{
        thr0: '1, thr1: '1, thr2: '1,
        up0:  '1, up1:  '1, up2:  '1,
        ten:  '0, mult: '0, occ:  '1,
        fd:   '0, fn:   '0, intg: '0, hold: '0
    };

    logic [1:0]            r_phase;
    logic                  r_pending;
    logic                  r_done;
    cfg_t                  r_shadow;
    cfg_t                  r_active;
    state_t                r_state;
    state_t                w_state_nx;
    logic [c_TW-1:0]       r_cnt;
    logic [c_TW-1:0]       w_cnt_nx;
    logic                  w_fire;
    logic                  r_trig;
    logic [CNT_BITS-1:0]   r_count;

    logic w_tick;
    logic w_xfer;
    logic w_wr;

    assign w_tick = (r_phase == 2'd0);
    assign w_xfer = (r_phase == 2'd2) && (r_pending || cfg.CFG_COMMIT);
    assign w_wr   = cfg.CFG_WR && !r_pending;

    always_ff @(posedge CLK120 or negedge RSTN) begin
        if (!RSTN) begin
            r_phase   <= 2'd0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_phase   <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
            r_done    <= w_xfer;
            if (w_xfer)
                r_pending <= 1'b0;
            else if (cfg.CFG_COMMIT)
                r_pending <= 1'b1;
        end
    end

    always_ff @(posedge CLK120 or negedge RSTN) begin
        if (!RSTN) begin
            r_shadow <= c_CFG_RST;
        end else if (w_wr) begin
            case (cfg.CFG_ADDR)
                4'd0:  r_shadow.thr0 <= cfg.CFG_DATA[ADC_WIDTH-1:0];
                4'd1:  r_shadow.thr1 <= cfg.CFG_DATA[ADC_WIDTH-1:0];
                4'd2:  r_shadow.thr2 <= cfg.CFG_DATA[ADC_WIDTH-1:0];
                4'd3:  r_shadow.up0  <= cfg.CFG_DATA[ADC_WIDTH-1:0];
                4'd4:  r_shadow.up1  <= cfg.CFG_DATA[ADC_WIDTH-1:0];
                4'd5:  r_shadow.up2  <= cfg.CFG_DATA[ADC_WIDTH-1:0];
                4'd6: begin
                    r_shadow.ten  <= cfg.CFG_DATA[4:2];
                    r_shadow.mult <= cfg.CFG_DATA[1:0];
                end
                4'd7:  r_shadow.occ  <= cfg.CFG_DATA[OCC_BITS-1:0];
                4'd8:  r_shadow.fd   <= cfg.CFG_DATA[FD_BITS-1:0];
                4'd9:  r_shadow.fn   <= cfg.CFG_DATA[FN_BITS-1:0];
                4'd10: r_shadow.intg <= cfg.CFG_DATA[INT_BITS-1:0];
                4'd11: r_shadow.hold <= cfg.CFG_DATA[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK120 or negedge RSTN) begin
        if (!RSTN)
            r_active <= c_CFG_RST;
        else if (w_xfer)
            r_active <= r_shadow;
    end

    always_ff @(posedge CLK120 or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_FLUSH;
            r_cnt   <= c_TW'(SETTLE_TICKS);
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_fire     = 1'b0;
        case (r_state)
            S_FLUSH: begin
                if (w_tick) begin
                    if (r_cnt <= c_TW'(1))
                        w_state_nx = S_ARMED;
                    else
                        w_cnt_nx = r_cnt - c_TW'(1);
                end
            end
            S_ARMED: begin
                if (TRIG_IN) begin
                    w_fire     = 1'b1;
                    w_state_nx = S_HOLDOFF;
                    w_cnt_nx   = c_TW'(r_active.hold);
                end
            end
            S_HOLDOFF: begin
                // Zero holdoff still masks one cycle before re-arming.
                if (r_cnt == '0)
                    w_state_nx = S_ARMED;
                else if (w_tick) begin
                    if (r_cnt <= c_TW'(1))
                        w_state_nx = S_ARMED;
                    else
                        w_cnt_nx = r_cnt - c_TW'(1);
                end
            end
            default: w_state_nx = S_FLUSH;
        endcase
        if (w_xfer) begin
            w_state_nx = S_FLUSH;
            w_cnt_nx   = c_TW'(SETTLE_TICKS);
        end
    end

    always_ff @(posedge CLK120 or negedge RSTN) begin
        if (!RSTN) begin
            r_trig  <= 1'b0;
            r_count <= '0;
        end else begin
            r_trig <= w_fire;
            if (CNT_CLR)
                r_count <= '0;
            else if (w_fire && (r_count != '1))
                r_count <= r_count + 1'b1;
        end
    end

    assign cfg.CFG_READY   = !r_pending;
    assign cfg.COMMIT_DONE = r_done;
    assign ENABLE40        = r_phase;
    assign THRES0          = r_active.thr0;
    assign THRES1          = r_active.thr1;
    assign THRES2          = r_active.thr2;
    assign UP0             = r_active.up0;
    assign UP1             = r_active.up1;
    assign UP2             = r_active.up2;
    assign TRIG_ENABLE     = r_active.ten;
    assign MULTIPLICITY    = r_active.mult;
    assign OCCUPANCY       = r_active.occ;
    assign FD              = r_active.fd;
    assign FN              = r_active.fn;
    assign INT             = r_active.intg;
    assign TRIG_OUT        = r_trig;
    assign TRIG_COUNT      = r_count;
    assign BUSY            = !((r_state == S_ARMED) && !r_pending);

endmodule
`default_nettype wire
